ballot_unit: RTL and testbench
==============================

# ballot_unit

Voter-side ballot terminal that drives the voting machine's vote-entry interface (one-hot `voter` plus `confirm` pulse). It debounces raw candidate, cast and cancel buttons and enforces one vote per officer authorization. On cast, it emits a clean, spaced confirm pulse that the counting block registers exactly once. It sits between the front-panel buttons and the voting machine's `ui_in[3:0]`/`ui_in[4]` inputs.

## Interface
- `DEBOUNCE_CYCLES`, 8: consecutive stable synchronized samples required before a button level is accepted.
- `CONFIRM_CYCLES`, 4: cycles `confirm_out` is held high per cast.
- `GAP_CYCLES`, 4: cycles `confirm_out` is held low after the pulse, with `voter_out` still held.
- `TIMEOUT_CYCLES`, 255: idle cycles allowed in ARMED or SELECTED before the ballot is voided.
- `clk` in 1: system clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `auth` in 1: officer authorization, synchronous level; sampled only in IDLE.
- `cand_btn` in 4: raw asynchronous candidate buttons, active-high.
- `cast_btn` in 1: raw asynchronous cast button.
- `cancel_btn` in 1: raw asynchronous cancel button.
- `voter_out` out 4: one-hot candidate to the voting machine; `4'b0000` when not sending.
- `confirm_out` out 1: confirm strobe to the voting machine.
- `ready` out 1: high in IDLE.
- `sel` out 4: current selection for the display; one-hot or zero.
- `cast_done` out 1: one-cycle pulse when a cast completes.
- `err` out 1: one-cycle pulse on an ambiguous candidate press.
- `timeout` out 1: one-cycle pulse when a ballot is voided.
- `ballot_cnt` out 8: completed casts; wraps from 255 to 0.

## Operation
- Button path, per input:
  - 2-flop synchronizer feeding a stability counter.
  - The debounced level updates after `DEBOUNCE_CYCLES` equal consecutive synchronized samples.
  - A press event is a registered rising edge of the debounced level.
- States: IDLE, ARMED, SELECTED, SETUP, SEND, GAP. The reset state is IDLE.
- IDLE:
  - `auth`=1 moves to ARMED and clears `sel`.
  - All buttons are ignored.
- ARMED / SELECTED, candidate press:
  - If the debounced `cand_btn` level is exactly one-hot in the event cycle, set `sel` to it and move to SELECTED. This also replaces an earlier selection.
  - Otherwise pulse `err`; state and `sel` are unchanged.
- ARMED / SELECTED, cancel press: clear `sel` and move to ARMED.
- SELECTED, cast press: move to SETUP. A cast press in ARMED is ignored.
- Priority within one cycle: cancel > cast > candidate.
- Timer:
  - Cleared on entry to ARMED and on every accepted event.
  - When it reaches `TIMEOUT_CYCLES`, move to IDLE, clear `sel`, pulse `timeout`, and leave `ballot_cnt` unchanged.
- SETUP: 1 cycle; `voter_out`=`sel`, `confirm_out`=0.
- SEND: `CONFIRM_CYCLES` cycles; `voter_out`=`sel`, `confirm_out`=1.
- GAP: `GAP_CYCLES` cycles; `voter_out`=`sel`, `confirm_out`=0. `cast_done` pulses in the last GAP cycle, then the state returns to IDLE.
- `ballot_cnt` increments on the `cast_done` cycle.
- Button events and `auth` are ignored in SETUP, SEND and GAP.
- All outputs except `ready` are registered. `ready` is decoded from state.

## Timing
- Reset values: `voter_out`=0, `confirm_out`=0, `sel`=0, `cast_done`=0, `err`=0, `timeout`=0, `ballot_cnt`=0, `ready`=1 (state IDLE).
- Debouncers reset to the released state. A button held through reset must be released and pressed again to generate an event.
- Debounce latency: raw input rising at cycle r (stable) gives a press event in cycle r+2+`DEBOUNCE_CYCLES`.
- `auth` high in IDLE at cycle a gives ARMED, with `ready`=0, at a+1.
- Cast event at cycle c:
  - SETUP at c+1.
  - `confirm_out` high for c+2 .. c+1+`CONFIRM_CYCLES`.
  - `cast_done` at c+1+`CONFIRM_CYCLES`+`GAP_CYCLES`.
  - IDLE one cycle later.
- `voter_out` is stable at least 1 cycle before the `confirm_out` rising edge and at least `GAP_CYCLES` after its falling edge.
- `rst` asserted mid-SEND or mid-GAP:
  - All outputs go to reset values at the next edge.
  - No `cast_done` is issued and `ballot_cnt` clears.
  - The downstream counter may already have registered the vote; this is accepted behaviour.

## Structure
- Shared package `ballot_pkg` holds:
  - state encoding constants (IDLE..GAP);
  - the one-hot candidate constants;
  - the `is_onehot4` function;
  - the counter width derivation (clog2 of the timers).
- Sub-module `btn_debounce` (synchronizer, stability counter, press-event output) is instantiated 6 times.
- The FSM, timer and output registers sit in `ballot_unit`.

## Test plan
- Reset, then `auth`=1 for 1 cycle, press `cand_btn`=0010, press cast. Required: `confirm_out` high exactly 4 cycles with `voter_out`=0010, `cast_done` 1 pulse, `ballot_cnt`=1, return to IDLE.
- A press bouncing 3 cycles high, 2 low, then stable, with `DEBOUNCE_CYCLES`=8. Required: exactly one press event, at stable start+10.
- `cand_btn`=0101 pressed together in ARMED. Required: `err` 1 pulse, `sel`=0, state ARMED. Then press 0100, then 1000. Required: `sel`=1000.
- Select 0001, then cancel, then cast. Required: `sel`=0 and no `confirm_out`. Cast in IDLE without `auth`: no output.
- `auth` then no input for 255 cycles. Required: `timeout` pulse, `ready`=1, `ballot_cnt` unchanged.
- 256 full casts. Required: `ballot_cnt` wraps to 0. Separately, `rst` during SEND: `confirm_out`=0 next cycle, no `cast_done`.

Source files
------------

// File: rtl/ballot_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ballot_pkg
//  Description : Shared constants and helpers for the ballot terminal:
//                FSM state encoding, one-hot candidate codes, the one-hot
//                test and the counter width derivation.
//  Revision    : 1.0 - initial release
// ============================================================================
package ballot_pkg;

    // FSM state encoding
    localparam int              c_STATE_W     = 3;
    localparam logic [2:0]      c_ST_IDLE     = 3'd0;
    localparam logic [2:0]      c_ST_ARMED    = 3'd1;
    localparam logic [2:0]      c_ST_SELECTED = 3'd2;
    localparam logic [2:0]      c_ST_SETUP    = 3'd3;
    localparam logic [2:0]      c_ST_SEND     = 3'd4;
    localparam logic [2:0]      c_ST_GAP      = 3'd5;

    // One-hot candidate codes as presented to the voting machine
    localparam logic [3:0]      c_CAND_NONE   = 4'b0000;
    localparam logic [3:0]      c_CAND_0      = 4'b0001;
    localparam logic [3:0]      c_CAND_1      = 4'b0010;
    localparam logic [3:0]      c_CAND_2      = 4'b0100;
    localparam logic [3:0]      c_CAND_3      = 4'b1000;

    // True only when exactly one candidate line is set
    function automatic logic is_onehot4(input logic [3:0] v);
        logic r;
        case (v)
            c_CAND_0, c_CAND_1, c_CAND_2, c_CAND_3: r = 1'b1;
            default:                                r = 1'b0;
        endcase
        return r;
    endfunction

    // Bits needed for a counter that runs 0 .. n-1 (at least one bit)
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : One raw button: 2-flop synchronizer, stability counter,
//                debounced level and a registered press (rising) event.
//                A button held through reset must first be seen released
//                for a full debounce window before it can produce a press.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce
    import ballot_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_press
);

    localparam int               c_CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic               r_press;
    logic               r_released;
    logic [c_CNT_W-1:0] r_chg_cnt;
    logic [c_CNT_W-1:0] r_low_cnt;

    // Synchronize, count consecutive differing samples, accept new level
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_level    <= 1'b0;
            r_press    <= 1'b0;
            r_released <= 1'b0;
            r_chg_cnt  <= '0;
            r_low_cnt  <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;

            // Level flips once DEBOUNCE_CYCLES samples in a row disagree with it
            if (r_sync2 == r_level) begin
                r_chg_cnt <= '0;
            end else if (r_chg_cnt == c_CNT_LAST) begin
                r_chg_cnt <= '0;
                r_level   <= r_sync2;
                r_press   <= r_sync2 & r_released;
            end else begin
                r_chg_cnt <= r_chg_cnt + c_CNT_ONE;
            end

            // Presses are only honoured after a full window of release
            if (r_sync2) begin
                r_low_cnt <= '0;
            end else if (!r_released) begin
                if (r_low_cnt == c_CNT_LAST) begin
                    r_released <= 1'b1;
                end else begin
                    r_low_cnt <= r_low_cnt + c_CNT_ONE;
                end
            end
        end
    end

    assign o_level = r_level;
    assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/ballot_unit.sv
`default_nettype none
// ============================================================================
//  Module      : ballot_unit
//  Description : Voter-side ballot terminal. Debounces the front-panel
//                buttons, enforces one vote per officer authorization and
//                drives the voting machine's one-hot voter lines plus a
//                clean, spaced confirm pulse on each cast.
//  Revision    : 1.0 - initial release
// ============================================================================
module ballot_unit
    import ballot_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int CONFIRM_CYCLES  = 4,
    parameter int GAP_CYCLES      = 4,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       auth,
    input  logic [3:0] cand_btn,
    input  logic       cast_btn,
    input  logic       cancel_btn,
    output logic [3:0] voter_out,
    output logic       confirm_out,
    output logic       ready,
    output logic [3:0] sel,
    output logic       cast_done,
    output logic       err,
    output logic       timeout,
    output logic [7:0] ballot_cnt
);

    localparam int                 c_TMR_W     = cnt_width(TIMEOUT_CYCLES);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST  = c_TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_ONE   = c_TMR_W'(1);

    localparam int                 c_PH_W      = cnt_width(max_int(CONFIRM_CYCLES, GAP_CYCLES));
    localparam logic [c_PH_W-1:0]  c_SEND_LAST = c_PH_W'(CONFIRM_CYCLES - 1);
    localparam logic [c_PH_W-1:0]  c_GAP_LAST  = c_PH_W'(GAP_CYCLES - 1);
    localparam logic [c_PH_W-1:0]  c_GAP_PRE   = c_PH_W'(GAP_CYCLES - 2);
    localparam logic [c_PH_W-1:0]  c_PH_ONE    = c_PH_W'(1);

    // Button index map: [3:0] candidates, [4] cast, [5] cancel
    localparam int                 c_NUM_BTN   = 6;
    localparam int                 c_IDX_CAST  = 4;
    localparam int                 c_IDX_CNCL  = 5;

    logic [c_NUM_BTN-1:0] w_raw;
    logic [c_NUM_BTN-1:0] w_level;
    logic [c_NUM_BTN-1:0] w_press;
    logic [1:0]           w_unused_lvl;

    logic [3:0]           w_cand_level;
    logic                 w_cand_press;
    logic                 w_cast_press;
    logic                 w_cancel_press;
    logic                 w_cand_ok;

    logic [c_STATE_W-1:0] r_state;
    logic [c_TMR_W-1:0]   r_timer;
    logic [c_PH_W-1:0]    r_phase;
    logic [3:0]           r_voter;
    logic                 r_confirm;
    logic [3:0]           r_sel;
    logic                 r_cast_done;
    logic                 r_err;
    logic                 r_timeout;
    logic [7:0]           r_ballot_cnt;

    assign w_raw = {cancel_btn, cast_btn, cand_btn};

    generate
        for (genvar gi = 0; gi < c_NUM_BTN; gi++) begin : g_debounce
            btn_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_btn (
                .clk     (clk),
                .rst     (rst),
                .i_raw   (w_raw[gi]),
                .o_level (w_level[gi]),
                .o_press (w_press[gi])
            );
        end
    endgenerate

    // Only candidate levels matter; cast/cancel are used purely as events
    assign w_unused_lvl   = w_level[c_IDX_CNCL:c_IDX_CAST];

    assign w_cand_level   = w_level[3:0];
    assign w_cand_press   = |w_press[3:0];
    assign w_cast_press   = w_press[c_IDX_CAST];
    assign w_cancel_press = w_press[c_IDX_CNCL];
    assign w_cand_ok      = is_onehot4(w_cand_level);

    // Ballot FSM with inactivity timer and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_timer      <= '0;
            r_phase      <= '0;
            r_voter      <= c_CAND_NONE;
            r_confirm    <= 1'b0;
            r_sel        <= c_CAND_NONE;
            r_cast_done  <= 1'b0;
            r_err        <= 1'b0;
            r_timeout    <= 1'b0;
            r_ballot_cnt <= 8'd0;
        end else begin
            r_err       <= 1'b0;
            r_timeout   <= 1'b0;
            r_cast_done <= 1'b0;

            case (r_state)
                c_ST_IDLE: begin
                    r_voter   <= c_CAND_NONE;
                    r_confirm <= 1'b0;
                    if (auth) begin
                        r_state <= c_ST_ARMED;
                        r_sel   <= c_CAND_NONE;
                        r_timer <= '0;
                    end
                end

                c_ST_ARMED, c_ST_SELECTED: begin
                    // cancel > cast > candidate; cast only counts once selected
                    if (w_cancel_press) begin
                        r_sel   <= c_CAND_NONE;
                        r_state <= c_ST_ARMED;
                        r_timer <= '0;
                    end else if (w_cast_press && (r_state == c_ST_SELECTED)) begin
                        r_state   <= c_ST_SETUP;
                        r_voter   <= r_sel;
                        r_confirm <= 1'b0;
                        r_timer   <= '0;
                    end else if (w_cand_press && w_cand_ok) begin
                        r_sel   <= w_cand_level;
                        r_state <= c_ST_SELECTED;
                        r_timer <= '0;
                    end else begin
                        // Ambiguous press is flagged but does not reset the timer
                        if (w_cand_press) begin
                            r_err <= 1'b1;
                        end
                        if (r_timer == c_TMR_LAST) begin
                            r_state   <= c_ST_IDLE;
                            r_sel     <= c_CAND_NONE;
                            r_timeout <= 1'b1;
                            r_timer   <= '0;
                        end else begin
                            r_timer <= r_timer + c_TMR_ONE;
                        end
                    end
                end

                c_ST_SETUP: begin
                    // voter lines already settled for one cycle
                    r_state   <= c_ST_SEND;
                    r_confirm <= 1'b1;
                    r_phase   <= '0;
                end

                c_ST_SEND: begin
                    if (r_phase == c_SEND_LAST) begin
                        r_state   <= c_ST_GAP;
                        r_confirm <= 1'b0;
                        r_phase   <= '0;
                        if (GAP_CYCLES == 1) begin
                            r_cast_done  <= 1'b1;
                            r_ballot_cnt <= r_ballot_cnt + 8'd1;
                        end
                    end else begin
                        r_phase <= r_phase + c_PH_ONE;
                    end
                end

                c_ST_GAP: begin
                    // voter held low-confirm; done pulse lands in the final GAP cycle
                    if (r_phase == c_GAP_LAST) begin
                        r_state <= c_ST_IDLE;
                        r_voter <= c_CAND_NONE;
                        r_phase <= '0;
                    end else begin
                        r_phase <= r_phase + c_PH_ONE;
                        if ((GAP_CYCLES >= 2) && (r_phase == c_GAP_PRE)) begin
                            r_cast_done  <= 1'b1;
                            r_ballot_cnt <= r_ballot_cnt + 8'd1;
                        end
                    end
                end

                default: begin
                    r_state   <= c_ST_IDLE;
                    r_voter   <= c_CAND_NONE;
                    r_confirm <= 1'b0;
                end
            endcase
        end
    end

    assign ready       = (r_state == c_ST_IDLE);
    assign voter_out   = r_voter;
    assign confirm_out = r_confirm;
    assign sel         = r_sel;
    assign cast_done   = r_cast_done;
    assign err         = r_err;
    assign timeout     = r_timeout;
    assign ballot_cnt  = r_ballot_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ballot_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ballot_unit
//  Description : Self-checking bench for ballot_unit. A behavioural model
//                (sample-window debounce, cast timeline by elapsed cycles)
//                is compared with the DUT every cycle; directed scenarios
//                add literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ballot_unit;

    localparam int D = 8;
    localparam int C = 4;
    localparam int G = 4;
    localparam int T = 255;

    logic       clk = 1'b0;
    logic       rst;
    logic       auth;
    logic [3:0] cand_btn;
    logic       cast_btn;
    logic       cancel_btn;
    logic [3:0] voter_out;
    logic       confirm_out;
    logic       ready;
    logic [3:0] sel;
    logic       cast_done;
    logic       err;
    logic       timeout;
    logic [7:0] ballot_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    ballot_unit #(
        .DEBOUNCE_CYCLES (D),
        .CONFIRM_CYCLES  (C),
        .GAP_CYCLES      (G),
        .TIMEOUT_CYCLES  (T)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .auth        (auth),
        .cand_btn    (cand_btn),
        .cast_btn    (cast_btn),
        .cancel_btn  (cancel_btn),
        .voter_out   (voter_out),
        .confirm_out (confirm_out),
        .ready       (ready),
        .sel         (sel),
        .cast_done   (cast_done),
        .err         (err),
        .timeout     (timeout),
        .ballot_cnt  (ballot_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural model ----------------
    logic [63:0] m_hist [6];
    logic [5:0]  m_lvl, m_prs, m_rel;
    int          m_since, m_mode, m_t, m_idle;
    logic [3:0]  m_sel, m_voter;
    logic        m_conf, m_done, m_err, m_to;
    logic [7:0]  m_cnt;
    logic [5:0]  t_pr, t_raw;
    logic [3:0]  t_lv;
    logic [D-1:0] t_win;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            for (int b = 0; b < 6; b++) m_hist[b] = '0;
            m_lvl = '0; m_prs = '0; m_rel = '0; m_since = 0;
            m_mode = 0; m_t = 0; m_idle = 0;
            m_sel = '0; m_voter = '0; m_conf = 0; m_done = 0; m_err = 0; m_to = 0; m_cnt = '0;
        end else begin
            t_pr = m_prs;
            t_lv = m_lvl[3:0];
            m_err = 0; m_to = 0; m_done = 0;
            case (m_mode)
                0: begin
                    m_voter = '0; m_conf = 0;
                    if (auth) begin m_mode = 1; m_sel = '0; m_idle = 0; end
                end
                1, 2: begin
                    if (t_pr[5]) begin
                        m_sel = '0; m_mode = 1; m_idle = 0;
                    end else if (t_pr[4] && m_mode == 2) begin
                        m_mode = 3; m_t = 1; m_voter = m_sel; m_conf = 0;
                    end else if ((|t_pr[3:0]) && $countones(t_lv) == 1) begin
                        m_sel = t_lv; m_mode = 2; m_idle = 0;
                    end else begin
                        if (|t_pr[3:0]) m_err = 1;
                        if (m_idle == T - 1) begin
                            m_mode = 0; m_sel = '0; m_to = 1;
                        end else begin
                            m_idle++;
                        end
                    end
                end
                default: begin
                    m_t++;
                    if (m_t == 2 + C + G) begin
                        m_mode = 0; m_voter = '0; m_conf = 0;
                    end else begin
                        m_conf = (m_t >= 2) && (m_t <= 1 + C);
                        if (m_t == 1 + C + G) begin m_done = 1; m_cnt = m_cnt + 8'd1; end
                    end
                end
            endcase
            // buttons: synchronized sample at this edge is the raw value two edges back
            t_raw = {cancel_btn, cast_btn, cand_btn};
            m_since++;
            for (int b = 0; b < 6; b++) begin
                m_hist[b] = {m_hist[b][62:0], t_raw[b]};
                t_win = m_hist[b][2 +: D];
                m_prs[b] = 1'b0;
                if (t_win == {D{1'b1}} && !m_lvl[b]) begin
                    m_lvl[b] = 1'b1;
                    m_prs[b] = m_rel[b];
                end else if (t_win == '0 && m_lvl[b]) begin
                    m_lvl[b] = 1'b0;
                end
                if (m_since >= D && t_win == '0) m_rel[b] = 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            n_checks++;
            if ({voter_out, confirm_out, ready, sel, cast_done, err, timeout, ballot_cnt} !==
                {m_voter, m_conf, (m_mode == 0), m_sel, m_done, m_err, m_to, m_cnt}) begin
                n_errors++;
                $display("FAIL cycle_compare cyc=%0d dut{voter=%b conf=%b rdy=%b sel=%b done=%b err=%b to=%b cnt=%0d} model{voter=%b conf=%b rdy=%b sel=%b done=%b err=%b to=%b cnt=%0d}",
                         cyc, voter_out, confirm_out, ready, sel, cast_done, err, timeout, ballot_cnt,
                         m_voter, m_conf, (m_mode == 0), m_sel, m_done, m_err, m_to, m_cnt);
            end
        end
    end

    // ---------------- event monitors ----------------
    int         conf_cnt, done_cnt, err_cnt;
    int         first_conf_cyc, done_cyc;
    logic [3:0] conf_voter;
    logic       prev_conf = 1'b0;

    initial forever begin
        @(posedge clk);
        #1;
        if (confirm_out === 1'b1) begin
            conf_cnt++;
            conf_voter = voter_out;
            if (!prev_conf) first_conf_cyc = cyc;
        end
        if (cast_done === 1'b1) begin done_cnt++; done_cyc = cyc; end
        if (err === 1'b1) err_cnt++;
        prev_conf = (confirm_out === 1'b1);
    end

    task automatic clear_mon();
        conf_cnt = 0; done_cnt = 0; err_cnt = 0;
        first_conf_cyc = 0; done_cyc = 0; conf_voter = '0;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cyc=%0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; auth = 1'b0; cand_btn = '0; cast_btn = 1'b0; cancel_btn = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(D + 4);
    endtask

    task automatic pulse_auth();
        auth = 1'b1; tick(1); auth = 1'b0;
    endtask

    // mask bits: [3:0] candidates, [4] cast, [5] cancel
    task automatic press(input logic [5:0] m, input int hold, input int gap);
        {cancel_btn, cast_btn, cand_btn} = {cancel_btn, cast_btn, cand_btn} | m;
        tick(hold);
        {cancel_btn, cast_btn, cand_btn} = {cancel_btn, cast_btn, cand_btn} & ~m;
        tick(gap);
    endtask

    task automatic full_press(input logic [5:0] m);
        press(m, D + 4, D + 4);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int a_cyc, s_cyc;
    logic [5:0] rnd;

    initial begin
        rst = 1'b1; auth = 1'b0; cand_btn = '0; cast_btn = 1'b0; cancel_btn = 1'b0;
        clear_mon();
        tick(1);
        chk_en = 1'b1;

        // Reset state
        do_reset();
        check("reset_ready", ready, 1);
        check("reset_cnt", ballot_cnt, 0);
        check("reset_sel", sel, 0);

        // Basic cast of candidate 0010
        clear_mon();
        pulse_auth();
        check("armed_ready_low", ready, 0);
        full_press(6'b000010);
        check("sel_after_cand", sel, 4'b0010);
        full_press(6'b010000);
        tick(5);
        check("confirm_cycles", conf_cnt, 4);
        check("confirm_voter", conf_voter, 4'b0010);
        check("cast_done_pulses", done_cnt, 1);
        check("done_after_confirm", done_cyc - first_conf_cyc, C + G - 1);
        check("cnt_after_cast", ballot_cnt, 1);
        check("ready_after_cast", ready, 1);

        // Timeout: 255 idle cycles after arming
        a_cyc = cyc;
        pulse_auth();
        for (int i = 0; i < 400 && timeout !== 1'b1; i++) tick(1);
        check("timeout_seen", timeout, 1);
        check("timeout_cycle", cyc - a_cyc, T + 1);
        check("timeout_ready", ready, 1);
        check("timeout_cnt_kept", ballot_cnt, 1);

        // Reset during SEND
        clear_mon();
        pulse_auth();
        full_press(6'b000100);
        cast_btn = 1'b1;
        for (int i = 0; i < 40 && confirm_out !== 1'b1; i++) tick(1);
        check("send_reached", confirm_out, 1);
        tick(1);
        rst = 1'b1;
        tick(1);
        check("rst_confirm_low", confirm_out, 0);
        check("rst_cnt_clear", ballot_cnt, 0);
        rst = 1'b0; cast_btn = 1'b0;
        tick(20);
        check("rst_no_done", done_cnt, 0);

        // Bouncing press: 3 high, 2 low, then stable
        do_reset();
        clear_mon();
        pulse_auth();
        cand_btn[0] = 1'b1; tick(3);
        cand_btn[0] = 1'b0; tick(2);
        cand_btn[0] = 1'b1;
        s_cyc = cyc;
        for (int i = 0; i < 40 && sel == 4'b0000; i++) tick(1);
        check("bounce_sel_cycle", cyc - s_cyc, D + 3);
        check("bounce_sel", sel, 4'b0001);
        cand_btn = '0;
        tick(D + 4);

        // Ambiguous candidate press, then replacement
        do_reset();
        clear_mon();
        pulse_auth();
        full_press(6'b000101);
        check("ambig_err", err_cnt, 1);
        check("ambig_sel", sel, 0);
        check("ambig_armed", ready, 0);
        full_press(6'b000100);
        full_press(6'b001000);
        check("replace_sel", sel, 4'b1000);

        // Select, cancel, cast -> nothing sent
        do_reset();
        clear_mon();
        pulse_auth();
        full_press(6'b000001);
        full_press(6'b100000);
        full_press(6'b010000);
        check("cancel_sel", sel, 0);
        check("cancel_no_confirm", conf_cnt, 0);

        // Cast in IDLE without authorization
        do_reset();
        clear_mon();
        full_press(6'b010000);
        check("idle_cast_confirm", conf_cnt, 0);
        check("idle_cast_ready", ready, 1);

        // 256 casts wrap the counter
        do_reset();
        clear_mon();
        for (int i = 0; i < 256; i++) begin
            pulse_auth();
            press(6'(1 << $urandom_range(0, 3)), D + 3, D + 4);
            press(6'b010000, D + 3, D + 4);
        end
        check("wrap_done_count", done_cnt, 256);
        check("wrap_cnt", ballot_cnt, 0);

        // Randomized traffic checked by the model every cycle
        do_reset();
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 49) == 0) do_reset();
            case ($urandom_range(0, 9))
                0, 1: begin
                    auth = 1'b1; tick($urandom_range(1, 2)); auth = 1'b0;
                end
                2, 3, 4: press(6'($urandom_range(1, 15)), $urandom_range(D - 3, D + 6), $urandom_range(D + 2, D + 8));
                5: press(6'b010000, $urandom_range(D - 3, D + 6), $urandom_range(D + 2, D + 8));
                6: press(6'b100000, $urandom_range(D - 3, D + 6), $urandom_range(D + 2, D + 8));
                7: press(6'($urandom_range(1, 63)), $urandom_range(D, D + 6), $urandom_range(D + 2, D + 8));
                8: begin
                    if ($urandom_range(0, 4) == 0) tick(300);
                    else tick($urandom_range(0, 40));
                end
                default: begin
                    repeat (6) begin
                        rnd = 6'($urandom);
                        {cancel_btn, cast_btn, cand_btn} = rnd;
                        tick(1);
                    end
                    {cancel_btn, cast_btn, cand_btn} = '0;
                    tick(D + 4);
                end
            endcase
        end
        tick(30);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
